// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // Two's-complement overflow of the top nibble: carry into MSB xor carry out of MSB.
    function automatic logic signed_ovf(input logic msb_a, input logic msb_b,
                                        input logic msb_sum, input logic cout);
        return (msb_a ^ msb_b ^ msb_sum) ^ cout;
    endfunction

endpackage

// File: rtl/adder_nibble_sequencer_if.sv
// Operand/result handshake bundle of the nibble-serial adder.
// Carries out_ovf only when ADDER_SEQ_OVERFLOW_EN is defined.
interface adder_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic             out_ovf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef ADDER_SEQ_OVERFLOW_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef ADDER_SEQ_OVERFLOW_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/nibble_shift_reg.sv
// WIDTH-bit register with parallel load and a 4-bit right shift that inserts shift_in at the top.
module nibble_shift_reg
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                shift,
    input  logic [NIBBLE_W-1:0] shift_in,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    shifted
);

    logic [WIDTH-1:0] q_r;

    if (WIDTH == NIBBLE_W) begin : g_single
        assign shifted = shift_in;
    end else begin : g_multi
        assign shifted = {shift_in, q_r[WIDTH-1:NIBBLE_W]};
    end

    // Load takes priority over shift; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= load_val;
        end else if (shift) begin
            q_r <= shifted;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/adder_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder driving one external 4-bit adder slice, LSB nibble first.
// Optional signed-overflow output enabled by ADDER_SEQ_OVERFLOW_EN.
module adder_nibble_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adder_nibble_sequencer_if.slave   bus,
    output logic [NIBBLE_W-1:0]       add_a,
    output logic [NIBBLE_W-1:0]       add_b,
    output logic                      add_cin,
    input  logic [NIBBLE_W-1:0]       add_sum,
    input  logic                      add_cout
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("adder_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic             out_ovf_r;
`endif

    logic             load_s;
    logic             shift_s;
    logic [WIDTH-1:0] a_q_s, a_nxt_s;
    logic [WIDTH-1:0] b_q_s, b_nxt_s;
    logic [WIDTH-1:0] sum_q_s, sum_nxt_s;
    logic             unused_s;

    // Operand capture in IDLE, nibble shifting while RUN.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = bus.in_valid & in_ready_r;
        end else if (state_r == ST_RUN) begin
            shift_s = 1'b1;
        end else begin
            load_s  = 1'b0;
            shift_s = 1'b0;
        end
    end

    nibble_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk(clk), .rst_n(rst_n), .load(load_s), .load_val(bus.in_a),
        .shift(shift_s), .shift_in(4'h0), .q(a_q_s), .shifted(a_nxt_s)
    );

    nibble_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk(clk), .rst_n(rst_n), .load(load_s), .load_val(bus.in_b),
        .shift(shift_s), .shift_in(4'h0), .q(b_q_s), .shifted(b_nxt_s)
    );

    nibble_shift_reg #(.WIDTH(WIDTH)) u_sum_reg (
        .clk(clk), .rst_n(rst_n), .load(load_s), .load_val({WIDTH{1'b0}}),
        .shift(shift_s), .shift_in(add_sum), .q(sum_q_s), .shifted(sum_nxt_s)
    );

    // FSM with registered handshake, carry chain and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
`ifdef ADDER_SEQ_OVERFLOW_EN
            out_ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        carry_r    <= bus.in_cin;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        // Final carry goes to out_cout; the slice's cin returns to 0.
                        carry_r     <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_sum_r   <= sum_nxt_s;
                        out_cout_r  <= add_cout;
`ifdef ADDER_SEQ_OVERFLOW_EN
                        out_ovf_r   <= signed_ovf(a_q_s[3], b_q_s[3], add_sum[3], add_cout);
`endif
                        state_r     <= ST_DONE;
                    end else begin
                        carry_r <= add_cout;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_sum_r   <= {WIDTH{1'b0}};
                        out_cout_r  <= 1'b0;
`ifdef ADDER_SEQ_OVERFLOW_EN
                        out_ovf_r   <= 1'b0;
`endif
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    carry_r     <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand registers drain to zero after NIB shifts, so add_a/add_b are 0 outside RUN.
    assign add_a   = a_q_s[3:0];
    assign add_b   = b_q_s[3:0];
    assign add_cin = carry_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
`ifdef ADDER_SEQ_OVERFLOW_EN
    assign bus.out_ovf   = out_ovf_r;
`endif

    assign unused_s = ^{a_q_s, b_q_s, a_nxt_s, b_nxt_s, sum_q_s};

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// Self-checking bench: WIDTH=16 and WIDTH=4 sequencers, each wired to a behavioural 4-bit adder slice.
module tb_adder_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    adder_nibble_sequencer_if #(.WIDTH(16)) bus16();
    adder_nibble_sequencer_if #(.WIDTH(4))  bus4();

    logic [3:0] a16, b16, s16, a4, b4, s4;
    logic       ci16, co16, ci4, co4;

    assign {co16, s16} = {1'b0, a16} + {1'b0, b16} + {4'h0, ci16};
    assign {co4, s4}   = {1'b0, a4} + {1'b0, b4} + {4'h0, ci4};

    adder_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16),
        .add_a(a16), .add_b(b16), .add_cin(ci16), .add_sum(s16), .add_cout(co16)
    );

    adder_nibble_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .add_a(a4), .add_b(b4), .add_cin(ci4), .add_sum(s4), .add_cout(co4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          hold;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word add, signed overflow from operand/result signs.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
        return {ovf, s};
    endfunction

    // Expected carry into nibble j: carry out of the low 4*j bits.
    function automatic logic exp_nib_cin(input logic [15:0] a, input logic [15:0] b, input logic cin, input int j);
        logic [31:0] mask;
        logic [31:0] t;
        if (j == 0) return cin;
        mask = (32'd1 << (4 * j)) - 32'd1;
        t = ({16'h0, a} & mask) + ({16'h0, b} & mask) + {31'h0, cin};
        return t[4 * j];
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input int hold,
                          input logic [15:0] es, input logic ec, input logic eo);
        logic [3:0] rec_a[4];
        logic       rec_c[4];
        int lat;
        @(negedge clk);
        chk("in_ready_idle", bus16.in_ready, 1);
        bus16.in_valid  = 1'b1;
        bus16.in_a      = a;
        bus16.in_b      = b;
        bus16.in_cin    = cin;
        bus16.out_ready = (hold == 0);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat <= 20) begin
            if (lat < 4) begin
                rec_a[lat] = a16;
                rec_c[lat] = ci16;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        for (int j = 0; j < 4; j++) begin
            logic [15:0] sh;
            sh = a >> (4 * j);
            chk("add_a_nibble", rec_a[j], sh[3:0]);
            chk("add_cin_nibble", rec_c[j], exp_nib_cin(a, b, cin, j));
        end
        chk("out_sum", bus16.out_sum, es);
        chk("out_cout", bus16.out_cout, ec);
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("out_ovf", bus16.out_ovf, eo);
`else
        if (eo === 1'bx) chk("ovf_arg", eo, 0);
`endif
        for (int h = 0; h < hold; h++) begin
            bus16.in_valid = 1'b1;
            bus16.in_a     = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", bus16.out_valid, 1);
            chk("bp_sum", bus16.out_sum, es);
            chk("bp_in_ready", bus16.in_ready, 0);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", bus16.out_valid, 0);
        chk("ready_back", bus16.in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 0, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'hABCD, 16'h1111, 1'b0, 5, 16'hBCDE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 2, 16'hFFFE, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b1, 0, 16'h0001, 1'b1, 1'b1};

        bus16.in_valid = 1'b0; bus16.in_a = 16'h0; bus16.in_b = 16'h0;
        bus16.in_cin = 1'b0;   bus16.out_ready = 1'b1;
        bus4.in_valid = 1'b0;  bus4.in_a = 4'h0; bus4.in_b = 4'h0;
        bus4.in_cin = 1'b0;    bus4.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", bus16.out_valid, 0);
        chk("rst_in_ready", bus16.in_ready, 1);
        chk("rst_out_sum", bus16.out_sum, 0);
        chk("rst_out_cout", bus16.out_cout, 0);
        chk("rst_add_a", a16, 0);
        chk("rst_add_cin", ci16, 0);
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("rst_out_ovf", bus16.out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Reset while RUN is at cnt==2 discards the operation.
        @(negedge clk);
        bus16.in_valid = 1'b1; bus16.in_a = 16'h00FF; bus16.in_b = 16'h0F0F; bus16.in_cin = 1'b0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrun_rst_valid", bus16.out_valid, 0);
        chk("midrun_rst_ready", bus16.in_ready, 1);
        chk("midrun_rst_add_a", a16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrun_no_result", bus16.out_valid, 0);
        end
        run_op(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            logic [17:0] r;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            r  = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), r[15:0], r[16], r[17]);
        end

        // WIDTH=4: single RUN cycle.
        @(negedge clk);
        chk("w4_in_ready", bus4.in_ready, 1);
        bus4.in_valid = 1'b1; bus4.in_a = 4'hF; bus4.in_b = 4'h1; bus4.in_cin = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("w4_run_valid", bus4.out_valid, 0);
        chk("w4_add_a", a4, 4'hF);
        chk("w4_add_cin", ci4, 1);
        @(negedge clk);
        chk("w4_out_valid", bus4.out_valid, 1);
        chk("w4_out_sum", bus4.out_sum, 4'h1);
        chk("w4_out_cout", bus4.out_cout, 1);
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("w4_out_ovf", bus4.out_ovf, 0);
`endif
        @(negedge clk);
        chk("w4_valid_drop", bus4.out_valid, 0);
        chk("w4_ready_back", bus4.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
